// File: rtl/leading_one_normalizer_if.sv
// Valid/ready bus between the leading-one detector, the normalizer and its consumer.
// The normalizer connects to the slave side; the upstream/downstream logic uses the master side.
interface leading_one_normalizer_if #(
    parameter int WIDTH = 9,
    parameter int IDX_W = 5,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [IDX_W-1:0] in_index;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mant;
    logic [IDX_W-1:0] out_exp;
    logic             out_zero;
    logic             out_err;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_a, in_index, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_zero, out_err, err_count
    );

    modport slave (
        input  in_valid, in_a, in_index, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_zero, out_err, err_count
    );
endinterface

// File: rtl/leading_one_normalizer.sv
// Two-stage normalizer: shifts an operand so its leading one lands on the MSB,
// validating the detector's index and counting inconsistent beats.
module leading_one_normalizer #(
    parameter int WIDTH     = 9,
    parameter int IDX_W     = 5,
    parameter int ZERO_CODE = 31,
    parameter int CNT_W     = 8
) (
    input logic                  clk,
    input logic                  rst,
    leading_one_normalizer_if.slave bus
);
    localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] MAX_IDX   = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] WIDTH_IDX = IDX_W'(WIDTH);
    localparam logic [IDX_W-1:0] ZERO_IDX  = IDX_W'(ZERO_CODE);

    // Handshake enables
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s2_en;
    logic s1_en;
    logic in_fire;

    assign s2_en   = !s2_valid_reg || bus.out_ready;
    assign s1_en   = !s1_valid_reg || s2_en;
    assign in_fire = bus.in_valid && s1_en;

    assign bus.in_ready  = s1_en;
    assign bus.out_valid = s2_valid_reg;

    // Stage-1 classification of the incoming beat
    logic             zero_comb;
    logic             err_comb;
    logic [WIDTH-1:0] above_idx;
    logic [SH_W-1:0]  shamt_comb;

    always_comb begin
        zero_comb  = (bus.in_a == '0);
        above_idx  = bus.in_a >> bus.in_index;
        err_comb   = 1'b0;
        shamt_comb = '0;
        if (zero_comb) begin
            err_comb = (bus.in_index != ZERO_IDX);
        end else begin
            // A correct index has exactly one set bit at or above it: the leading one itself.
            err_comb = (bus.in_index >= WIDTH_IDX) || (above_idx != WIDTH'(1));
        end
        if (!zero_comb && !err_comb) begin
            shamt_comb = SH_W'(MAX_IDX - bus.in_index);
        end
    end

    logic [WIDTH-1:0] s1_a_reg;
    logic [IDX_W-1:0] s1_index_reg;
    logic             s1_zero_reg;
    logic             s1_err_reg;
    logic [SH_W-1:0]  s1_shamt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_index_reg <= '0;
            s1_zero_reg  <= 1'b0;
            s1_err_reg   <= 1'b0;
            s1_shamt_reg <= '0;
        end else if (s1_en) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a_reg     <= bus.in_a;
                s1_index_reg <= bus.in_index;
                s1_zero_reg  <= zero_comb;
                s1_err_reg   <= err_comb;
                s1_shamt_reg <= shamt_comb;
            end
        end
    end

    // Logarithmic barrel shifter; shamt is zero for zero/err beats so they pass unshifted.
    logic [WIDTH-1:0] shift_stage [0:SH_W];

    assign shift_stage[0] = s1_a_reg;

    generate
        for (genvar gi = 0; gi < SH_W; gi++) begin : g_shift
            assign shift_stage[gi+1] = s1_shamt_reg[gi] ? (shift_stage[gi] << (2 ** gi))
                                                        : shift_stage[gi];
        end
    endgenerate

    logic [WIDTH-1:0] mant_reg;
    logic [IDX_W-1:0] exp_reg;
    logic             zero_reg;
    logic             err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            mant_reg     <= '0;
            exp_reg      <= '0;
            zero_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else if (s2_en) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                mant_reg <= shift_stage[SH_W];
                exp_reg  <= s1_index_reg;
                zero_reg <= s1_zero_reg;
                err_reg  <= s1_err_reg;
            end
        end
    end

    assign bus.out_mant = mant_reg;
    assign bus.out_exp  = exp_reg;
    assign bus.out_zero = zero_reg;
    assign bus.out_err  = err_reg;

    logic [CNT_W-1:0] err_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_reg <= '0;
        end else if (in_fire && err_comb && (err_count_reg != '1)) begin
            err_count_reg <= err_count_reg + 1'b1;
        end
    end

    assign bus.err_count = err_count_reg;
endmodule

// File: tb/tb_leading_one_normalizer.sv
// Directed bench for leading_one_normalizer: hand-computed vectors, backpressure,
// a full operand sweep against a golden detector, and mid-stream reset.
module tb_leading_one_normalizer;
    logic clk;
    logic rst;

    leading_one_normalizer_if #(.WIDTH(9), .IDX_W(5), .CNT_W(8)) bus ();

    leading_one_normalizer #(
        .WIDTH(9), .IDX_W(5), .ZERO_CODE(31), .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] mant;
        logic [4:0] expo;
        logic       zero;
        logic       err;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, expv);
        end
    endtask

    function automatic logic [4:0] golden(input logic [8:0] a);
        logic [4:0] r;
        r = 5'd31;
        for (int i = 0; i < 9; i++) begin
            if (a[i]) r = 5'(i);
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [8:0] a, input logic [4:0] idx);
        exp_t e;
        e.zero = (a == 9'd0);
        e.expo = idx;
        if (e.zero) e.err = (idx != 5'd31);
        else        e.err = (idx >= 5'd9) || ((a >> idx) != 9'd1);
        if (e.zero || e.err) e.mant = a;
        else                 e.mant = a << (4'd8 - 4'(idx));
        return e;
    endfunction

    // Single beat through an idle pipe with out_ready held high.
    task automatic run_one(input string tag, input logic [8:0] a, input logic [4:0] idx,
                           input logic [8:0] em, input logic [4:0] ee,
                           input logic ez, input logic er);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_index  = idx;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_mant"},  32'(bus.out_mant),  32'(em));
        check({tag, "_exp"},   32'(bus.out_exp),   32'(ee));
        check({tag, "_zero"},  32'(bus.out_zero),  32'(ez));
        check({tag, "_err"},   32'(bus.out_err),   32'(er));
        $display("beat a=%h idx=%0d -> mant=%h exp=%0d zero=%0b err=%0b cnt=%0d",
                 a, idx, bus.out_mant, bus.out_exp, bus.out_zero, bus.out_err, bus.err_count);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Streams n operands base..base+n-1 with golden indices; out_ready low for
    // the first 'stall' cycles, then high or random.
    task automatic stream(input string tag, input int n, input int base,
                          input int stall, input bit rnd);
        exp_t q[$];
        exp_t e;
        int sent = 0;
        int cyc = 0;
        int got = 0;
        bit hold_v = 1'b0;
        logic [8:0] hm;
        logic [4:0] he;
        while ((sent < n || q.size() > 0) && cyc < 5000) begin
            @(negedge clk);
            if (hold_v) begin
                check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
                check({tag, "_hold_mant"},  32'(bus.out_mant),  32'(hm));
                check({tag, "_hold_exp"},   32'(bus.out_exp),   32'(he));
            end
            if (cyc < stall) bus.out_ready = 1'b0;
            else if (rnd)    bus.out_ready = 1'($urandom_range(0, 1));
            else             bus.out_ready = 1'b1;
            bus.in_valid = (sent < n);
            bus.in_a     = 9'(base + sent);
            bus.in_index = golden(9'(base + sent));
            #1;
            if (stall > 0 && cyc == 2) check({tag, "_in_ready_drop"}, 32'(bus.in_ready), 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                check({tag, "_unexpected_out"}, 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check({tag, "_mant"}, 32'(bus.out_mant), 32'(e.mant));
                    check({tag, "_exp"},  32'(bus.out_exp),  32'(e.expo));
                    check({tag, "_zero"}, 32'(bus.out_zero), 32'(e.zero));
                    check({tag, "_err"},  32'(bus.out_err),  32'(e.err));
                    if (!e.zero) check({tag, "_msb"}, 32'(bus.out_mant[8]), 32'd1);
                    got++;
                end
            end
            hold_v = bus.out_valid && !bus.out_ready;
            hm = bus.out_mant;
            he = bus.out_exp;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.in_a, bus.in_index));
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_all_sent"},    32'(sent), 32'(n));
        check({tag, "_all_received"}, 32'(got), 32'(n));
        $display("stream %s: sent=%0d received=%0d cycles=%0d cnt=%0d",
                 tag, sent, got, cyc, bus.err_count);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_index  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mant",      32'(bus.out_mant),  32'd0);
        check("rst_exp",       32'(bus.out_exp),   32'd0);
        check("rst_zero",      32'(bus.out_zero),  32'd0);
        check("rst_err",       32'(bus.out_err),   32'd0);
        check("rst_count",     32'(bus.err_count), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        $display("reset released");

        run_one("t1",      9'h001, 5'd0,  9'h100, 5'd0,  1'b0, 1'b0);
        run_one("t2a",     9'h0A5, 5'd7,  9'h14A, 5'd7,  1'b0, 1'b0);
        run_one("t2b",     9'h1FF, 5'd8,  9'h1FF, 5'd8,  1'b0, 1'b0);
        run_one("t3zero",  9'h000, 5'd31, 9'h000, 5'd31, 1'b1, 1'b0);
        check("t3_count0", 32'(bus.err_count), 32'd0);
        run_one("t3bad",   9'h000, 5'd3,  9'h000, 5'd3,  1'b1, 1'b1);
        check("t3_count1", 32'(bus.err_count), 32'd1);
        run_one("t4wrong", 9'h040, 5'd5,  9'h040, 5'd5,  1'b0, 1'b1);
        run_one("t4range", 9'h040, 5'd12, 9'h040, 5'd12, 1'b0, 1'b1);
        check("t4_count3", 32'(bus.err_count), 32'd3);

        // 300 more bad beats back to back: counter pins at 255
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 9'h040;
        bus.in_index  = 5'd5;
        repeat (300) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t4_saturate", 32'(bus.err_count), 32'd255);
        $display("saturation: cnt=%0d", bus.err_count);

        do_reset();
        check("clr_count", 32'(bus.err_count), 32'd0);

        stream("t5", 10, 0, 5, 1'b0);
        stream("t6", 512, 0, 0, 1'b1);
        check("t6_count", 32'(bus.err_count), 32'd0);

        // Mid-stream reset with beats in flight and a counted error
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 9'h040;
        bus.in_index  = 5'd5;
        @(posedge clk);
        @(negedge clk);
        bus.in_a     = 9'h001;
        bus.in_index = 5'd0;
        @(posedge clk);
        @(negedge clk);
        check("mid_count_before", 32'(bus.err_count), 32'd1);
        check("mid_valid_before", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_count",     32'(bus.err_count), 32'd0);
        check("mid_mant",      32'(bus.out_mant),  32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_no_ghost",  32'(bus.out_valid), 32'd0);
        $display("mid-stream reset: out_valid=%0b cnt=%0d", bus.out_valid, bus.err_count);

        run_one("recover", 9'h003, 5'd1, 9'h180, 5'd1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
